i2c_reg_ctrl: RTL and testbench
===============================

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000000: maximum cycles the block waits on any single byte handshake phase.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  user transaction request (4-phase).
REQ-005 ack  out  1  user transaction done.
REQ-006 r_wn  in  1  1 = register read, 0 = register write.
REQ-007 dev_addr  in  7  7-bit I2C device address.
REQ-008 reg_addr  in  8  device register address.
REQ-009 wr_data  in  8  write data.
REQ-010 rd_data  out  8  read data.
REQ-011 nack_err  out  1  a device byte was NACKed in the last transaction.
REQ-012 tmo_err  out  1  byte engine timed out in the last transaction.
REQ-013 busy  out  1  high from request accept until ack deasserts.
REQ-014 byte_req, byte_r_wn, byte_start, byte_ack_o, byte_stop  out  1 each  byte-engine request and controls.
REQ-015 byte_wr_data  out  8  byte-engine write data.
REQ-016 byte_ack  in  1  byte-engine transaction acknowledge.
REQ-017 byte_rd_data  in  8  byte-engine read data.
REQ-018 byte_acked  in  1  sampled SDA in the ACK slot; 1 = NACK.

Function
REQ-019 Byte sequence for a write: B0 = START + {dev_addr,0}; B1 = reg_addr; B2 = wr_data + STOP.
REQ-020 Byte sequence for a read: B0 = START + {dev_addr,0}; B1 = reg_addr; B2 = repeated START + {dev_addr,1}; B3 = read byte with byte_ack_o = 0 (master NACK) + STOP.
REQ-021 Write bytes drive byte_ack_o = 0 and byte_r_wn = 0; only B3 drives byte_r_wn = 1.
REQ-022 States: IDLE, LOAD, REQ, WAIT_ACK, RELEASE, RECOVER, DONE.
REQ-023 IDLE -> LOAD when req = 1 and ack = 0:
  - latch r_wn, dev_addr, reg_addr and wr_data;
  - clear nack_err and tmo_err;
  - set the byte index to 0 and assert busy.
REQ-024 LOAD drives the byte fields from the latched values and the byte index, then moves to REQ after 1 cycle.
REQ-025 REQ asserts byte_req, then moves to WAIT_ACK; byte-engine fields stay constant while byte_req = 1.
REQ-026 WAIT_ACK:
  - on byte_ack = 1, capture byte_rd_data into rd_data (B3 only) and byte_acked;
  - deassert byte_req and move to RELEASE.
REQ-027 RELEASE waits for byte_ack = 0, then branches:
  - write byte with byte_acked = 1: set nack_err and go to RECOVER;
  - last byte: go to DONE;
  - otherwise: increment the index and go to LOAD.
REQ-028 RECOVER issues one extra byte to release SDA and end the transaction, then goes to DONE:
  - byte_wr_data = 0xFF, byte_start = 0, byte_stop = 1, byte_ack_o = 0;
  - its byte_acked is ignored.
REQ-029 DONE asserts ack = 1 and holds rd_data and the error flags; when req = 0, it deasserts ack and busy and returns to IDLE.
REQ-030 A cycle counter clears on every entry to WAIT_ACK or RELEASE:
  - it counts while in either state;
  - if it reaches TIMEOUT_CYC - 1, the block sets tmo_err, deasserts byte_req and goes to DONE.
REQ-031 A NACK on B2 of a read aborts before B3, and rd_data stays 0x00.
REQ-032 Error flags and rd_data stay stable from DONE until the next accept.
REQ-033 Latency is 1 cycle from engine release to the next byte_req assert (LOAD, then REQ).
REQ-034 req changes while busy are ignored; the latched values govern the whole transaction.

Reset
REQ-035 While rst_n = 0, the block SHALL:
  - force state to IDLE and clear the index and counter;
  - drive ack, busy, nack_err, tmo_err, byte_req, byte_r_wn, byte_start, byte_ack_o and byte_stop to 0;
  - drive byte_wr_data and rd_data to 0x00.
REQ-036 Reset asserted mid-transaction SHALL abort immediately, with no recovery byte issued after release.

Verification
REQ-037 Write dev 0x50, reg 0x10, data 0xA5, all ACK -> bytes 0xA0(S), 0x10, 0xA5(P); ack = 1; nack_err = 0; tmo_err = 0.
REQ-038 Read dev 0x50, reg 0x22, model returns 0x3C -> bytes 0xA0(S), 0x22, 0xA1(S); B3 has r_wn = 1, byte_ack_o = 0, stop = 1; rd_data = 0x3C.
REQ-039 Write with B0 NACKed -> nack_err = 1; next byte is 0xFF with stop = 1, start = 0; no reg_addr byte sent; ack = 1.
REQ-040 Engine never acks, TIMEOUT_CYC = 16 -> tmo_err = 1 after 16 cycles in WAIT_ACK; byte_req = 0; ack = 1.
REQ-041 rst_n pulled low during B1 -> all outputs at reset values asynchronously; the next request runs normally from B0.
REQ-042 Back-to-back requests with req dropped for 1 cycle -> second transaction starts cleanly; error flags cleared on accept.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// I2C register-access sequencer: turns one user read/write request into the
// byte-level START/address/data/STOP sequence issued to an I2C byte engine.
module i2c_reg_ctrl #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   output logic       ack,
   input  logic       r_wn,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       nack_err,
   output logic       tmo_err,
   output logic       busy,
   output logic       byte_req,
   output logic       byte_r_wn,
   output logic       byte_start,
   output logic       byte_ack_o,
   output logic       byte_stop,
   output logic [7:0] byte_wr_data,
   input  logic       byte_ack,
   input  logic [7:0] byte_rd_data,
   input  logic       byte_acked
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_REQ      = 3'd2;
   localparam logic [2:0] S_WAIT_ACK = 3'd3;
   localparam logic [2:0] S_RELEASE  = 3'd4;
   localparam logic [2:0] S_RECOVER  = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam int            CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   logic [2:0]    state_reg;
   logic [1:0]    idx_reg;
   logic [CW-1:0] cnt_reg;
   logic          rw_reg;
   logic [6:0]    dev_reg;
   logic [7:0]    ra_reg;
   logic [7:0]    wd_reg;
   logic          acked_reg;
   logic          recov_reg;
   logic          last_byte;

   // Packed as {start, stop, r_wn, ack_o, data}; byte 3 is the read byte, master NACKs it
   function automatic logic [11:0] byte_fields(input logic [1:0] idx, input logic rw,
                                               input logic [6:0] dev, input logic [7:0] ra,
                                               input logic [7:0] wd);
      case (idx)
         2'd0:    return {4'b1000, dev, 1'b0};
         2'd1:    return {4'b0000, ra};
         2'd2:    return rw ? {4'b1000, dev, 1'b1} : {4'b0100, wd};
         default: return {4'b0110, 8'hFF};
      endcase
   endfunction

   assign last_byte = rw_reg ? (idx_reg == 2'd3) : (idx_reg == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         idx_reg      <= 2'd0;
         cnt_reg      <= '0;
         rw_reg       <= 1'b0;
         dev_reg      <= 7'd0;
         ra_reg       <= 8'd0;
         wd_reg       <= 8'd0;
         acked_reg    <= 1'b0;
         recov_reg    <= 1'b0;
         ack          <= 1'b0;
         busy         <= 1'b0;
         nack_err     <= 1'b0;
         tmo_err      <= 1'b0;
         rd_data      <= 8'd0;
         byte_req     <= 1'b0;
         byte_r_wn    <= 1'b0;
         byte_start   <= 1'b0;
         byte_ack_o   <= 1'b0;
         byte_stop    <= 1'b0;
         byte_wr_data <= 8'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (req && !ack) begin
                  rw_reg    <= r_wn;
                  dev_reg   <= dev_addr;
                  ra_reg    <= reg_addr;
                  wd_reg    <= wr_data;
                  nack_err  <= 1'b0;
                  tmo_err   <= 1'b0;
                  rd_data   <= 8'd0;
                  idx_reg   <= 2'd0;
                  recov_reg <= 1'b0;
                  busy      <= 1'b1;
                  {byte_start, byte_stop, byte_r_wn, byte_ack_o, byte_wr_data}
                     <= byte_fields(2'd0, r_wn, dev_addr, reg_addr, wr_data);
                  state_reg <= S_LOAD;
               end
            end
            // Byte fields are already settled here, one cycle ahead of byte_req
            S_LOAD, S_RECOVER: begin
               byte_req  <= 1'b1;
               state_reg <= S_REQ;
            end
            S_REQ: begin
               cnt_reg   <= '0;
               state_reg <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (byte_ack) begin
                  if (byte_r_wn) rd_data <= byte_rd_data;
                  acked_reg <= byte_acked;
                  byte_req  <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= S_RELEASE;
               end else if (cnt_reg == CNT_LAST) begin
                  tmo_err   <= 1'b1;
                  byte_req  <= 1'b0;
                  ack       <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!byte_ack) begin
                  if (recov_reg) begin
                     ack       <= 1'b1;
                     state_reg <= S_DONE;
                  end else if (!byte_r_wn && acked_reg) begin
                     // Send 0xFF + STOP so the bus is released after a NACK
                     nack_err  <= 1'b1;
                     recov_reg <= 1'b1;
                     {byte_start, byte_stop, byte_r_wn, byte_ack_o, byte_wr_data}
                        <= {4'b0100, 8'hFF};
                     state_reg <= S_RECOVER;
                  end else if (last_byte) begin
                     ack       <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     idx_reg <= idx_reg + 2'd1;
                     {byte_start, byte_stop, byte_r_wn, byte_ack_o, byte_wr_data}
                        <= byte_fields(idx_reg + 2'd1, rw_reg, dev_reg, ra_reg, wd_reg);
                     state_reg <= S_LOAD;
                  end
               end else if (cnt_reg == CNT_LAST) begin
                  tmo_err   <= 1'b1;
                  ack       <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DONE: begin
               if (!req) begin
                  ack       <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Randomized bench for i2c_reg_ctrl: a byte-engine model logs every issued
// byte and a sequence-level model predicts the bytes, flags and read data.
module tb_i2c_reg_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic       ack;
   logic       r_wn;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       nack_err;
   logic       tmo_err;
   logic       busy;
   logic       byte_req;
   logic       byte_r_wn;
   logic       byte_start;
   logic       byte_ack_o;
   logic       byte_stop;
   logic [7:0] byte_wr_data;
   logic       byte_ack;
   logic [7:0] byte_rd_data;
   logic       byte_acked;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [11:0] got_q[$];
   int          nack_idx = 9;
   logic [7:0]  rd_val   = 8'h00;
   bit          hang     = 1'b0;

   i2c_reg_ctrl #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .r_wn(r_wn),
      .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .rd_data(rd_data), .nack_err(nack_err), .tmo_err(tmo_err), .busy(busy),
      .byte_req(byte_req), .byte_r_wn(byte_r_wn), .byte_start(byte_start),
      .byte_ack_o(byte_ack_o), .byte_stop(byte_stop), .byte_wr_data(byte_wr_data),
      .byte_ack(byte_ack), .byte_rd_data(byte_rd_data), .byte_acked(byte_acked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Byte engine: logs {start,stop,r_wn,ack_o,data}, answers after a random delay
   initial begin
      int n;
      byte_ack = 1'b0; byte_acked = 1'b0; byte_rd_data = 8'h00;
      forever begin
         @(negedge clk);
         if (byte_req && !byte_ack && !hang) begin
            n = got_q.size();
            got_q.push_back({byte_start, byte_stop, byte_r_wn, byte_ack_o, byte_wr_data});
            repeat ($urandom_range(0, 3)) @(negedge clk);
            byte_rd_data = (n == 3) ? rd_val : 8'($urandom);
            byte_acked   = (n == nack_idx) || (nack_idx < 3 && n == nack_idx + 1);
            byte_ack     = 1'b1;
            for (int k = 0; k < 200 && byte_req; k++) @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            byte_ack = 1'b0;
         end
      end
   end

   task automatic do_txn(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input logic [7:0] rv, input int nk, input bit hg);
      logic [11:0] exp_q[$];
      bit          exp_nack;
      logic [7:0]  exp_rd;
      int          req_cyc;
      bit          seen;
      // Reference: the full I2C byte list, cut short after a NACKed write byte
      exp_q.push_back({4'b1000, dev, 1'b0});
      exp_q.push_back({4'b0000, ra});
      if (rw) begin
         exp_q.push_back({4'b1000, dev, 1'b1});
         exp_q.push_back({4'b0110, 8'h00});
      end else begin
         exp_q.push_back({4'b0100, wd});
      end
      exp_nack = (nk < 3);
      exp_rd   = (rw && !exp_nack) ? rv : 8'h00;
      if (exp_nack) begin
         while (exp_q.size() > nk + 1) void'(exp_q.pop_back());
         exp_q.push_back({4'b0100, 8'hFF});
      end
      if (hg) begin
         exp_q.delete();
         exp_nack = 1'b0;
         exp_rd   = 8'h00;
      end
      got_q.delete();
      nack_idx = nk; rd_val = rv; hang = hg;
      r_wn = rw; dev_addr = dev; reg_addr = ra; wr_data = wd; req = 1'b1;
      @(negedge clk);
      chk("accept_busy", busy, 1'b1);
      chk("accept_flags_clr", {nack_err, tmo_err}, 2'b00);
      // Inputs changing while busy must not affect the transaction
      r_wn = ~rw; dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
      req_cyc = 0; seen = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (ack) begin seen = 1'b1; break; end
         if (byte_req) req_cyc++;
      end
      chk("ack_seen", seen, 1'b1);
      chk("nbytes", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("byte%0d_ctrl", i), got_q[i][11:8], exp_q[i][11:8]);
         if (!exp_q[i][9]) chk($sformatf("byte%0d_data", i), got_q[i][7:0], exp_q[i][7:0]);
      end
      chk("rd_data", rd_data, exp_rd);
      chk("nack_err", nack_err, exp_nack);
      chk("tmo_err", tmo_err, hg);
      chk("byte_req_idle", byte_req, 1'b0);
      if (hg) chk("tmo_cycles", (req_cyc >= 16 && req_cyc <= 17), 1'b1);
      $display("txn rw=%0d dev=%02h reg=%02h wd=%02h nk=%0d hang=%0d -> bytes=%0d rd=%02h nack=%0d tmo=%0d",
               rw, dev, ra, wd, nk, hg, got_q.size(), rd_data, nack_err, tmo_err);
      req = 1'b0;
      @(negedge clk);
      chk("ack_drop", {ack, busy}, 2'b00);
      chk("hold_result", {rd_data, nack_err, tmo_err}, {exp_rd, exp_nack, hg});
      hang = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; req = 1'b0; r_wn = 1'b0;
      dev_addr = 7'h00; reg_addr = 8'h00; wr_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {ack, busy, nack_err, tmo_err, byte_req, byte_r_wn, byte_start, byte_ack_o, byte_stop}, 9'd0);
      chk("reset_data", {rd_data, byte_wr_data}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 9, 1'b0);
      do_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 9, 1'b0);
      do_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 1'b0);
      do_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 9, 1'b1);
      do_txn(1'b1, 7'h2B, 8'h7E, 8'h00, 8'hC3, 2, 1'b0);

      // Reset while byte 1 is in flight
      got_q.delete(); nack_idx = 9; hang = 1'b0;
      r_wn = 1'b0; dev_addr = 7'h33; reg_addr = 8'h5A; wr_data = 8'h99; req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (got_q.size() >= 2) begin seen = 1'b1; break; end
      end
      chk("reached_b1", seen, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {ack, busy, nack_err, tmo_err, byte_req, byte_r_wn, byte_start, byte_ack_o, byte_stop}, 9'd0);
      chk("midrst_data", {rd_data, byte_wr_data}, 16'd0);
      req = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("no_recover_after_rst", got_q.size(), 2);
      do_txn(1'b0, 7'h33, 8'h5A, 8'h99, 8'h00, 9, 1'b0);

      for (int t = 0; t < 40; t++) begin
         do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
